ldb_burst_splitter: RTL and testbench

- Upstream stage of the LDB AXI read master.
- Accepts one load command: base address plus total byte count.
- Splits the command into legal AXI INCR bursts and drives them one at a time into the read master's simple request interface (req_valid/req_ready/req_addr/req_len, req_done/req_err).
- Reports one aggregated completion per command.

---
 rtl/ldb_pkg.sv | 27 ++
 rtl/ldb_burst_len_calc.sv | 30 +++
 rtl/ldb_burst_splitter.sv | 135 +++++++++++++
 tb/tb_ldb_burst_splitter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ldb_pkg.sv
`default_nettype none
// ============================================================================
// ldb_pkg : shared types, constants and helpers for the LDB burst splitter
// Revision: 1.0
// ============================================================================
package ldb_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } split_state_t;

  localparam int unsigned AXI_4K_BYTES = 4096;

  function automatic logic [12:0] min3(input logic [12:0] a,
                                       input logic [12:0] b,
                                       input logic [12:0] c);
    logic [12:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ldb_burst_len_calc.sv
`default_nettype none
// ============================================================================
// ldb_burst_len_calc : beats for the next burst, limited by remaining beats,
// MAX_BURST and the distance to the next 4KB boundary.
// Revision: 1.0
// ============================================================================
module ldb_burst_len_calc
  import ldb_pkg::*;
#(
  parameter int ADDR_LSB  = 4,
  parameter int REM_W     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic [11:0]      addr_lo,
  input  logic [REM_W-1:0] remaining,
  output logic [8:0]       len
);

  logic [12:0] to_4k;
  logic [12:0] rem_clip;

  always_comb begin
    // Beat-aligned address keeps this term >= 1; 13 bits holds the full 4096.
    to_4k    = (13'(AXI_4K_BYTES) - {1'b0, addr_lo}) >> ADDR_LSB;
    rem_clip = (remaining > REM_W'(MAX_BURST)) ? 13'(MAX_BURST) : 13'(remaining);
    len      = 9'(min3(rem_clip, 13'(MAX_BURST), to_4k));
  end

endmodule
`default_nettype wire

// File: rtl/ldb_burst_splitter.sv
`default_nettype none
// ============================================================================
// ldb_burst_splitter : splits one load command into AXI INCR bursts for the
// read master and reports one aggregated completion.
// Revision: 1.0
// ============================================================================
module ldb_burst_splitter
  import ldb_pkg::*;
#(
  parameter int AXI_ADDR_W   = 64,
  parameter int AXI_DATA_W   = 128,
  parameter int MAX_BURST    = 16,
  parameter int LEN_W        = 32,
  parameter bit ABORT_ON_ERR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AXI_ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]      cmd_bytes,
  output logic                  cmd_done,
  output logic                  cmd_err,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [AXI_ADDR_W-1:0] req_addr,
  output logic [8:0]            req_len,
  input  logic                  req_done,
  input  logic                  req_err,
  output logic                  busy,
  output logic [15:0]           burst_cnt
);

  localparam int DATA_BYTES = AXI_DATA_W / 8;
  localparam int ADDR_LSB   = $clog2(DATA_BYTES);

  split_state_t          state, state_nxt;
  logic [AXI_ADDR_W-1:0] addr;
  logic [LEN_W-1:0]      remaining;
  logic                  err_sticky;
  logic [8:0]            calc_len;
  logic                  cmd_illegal;

  assign cmd_illegal = (cmd_bytes == '0) ||
                       (cmd_addr[ADDR_LSB-1:0] != '0) ||
                       (cmd_bytes[ADDR_LSB-1:0] != '0);

  ldb_burst_len_calc #(
    .ADDR_LSB  (ADDR_LSB),
    .REM_W     (LEN_W),
    .MAX_BURST (MAX_BURST)
  ) u_len_calc (
    .addr_lo   (addr[11:0]),
    .remaining (remaining),
    .len       (calc_len)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_valid) state_nxt = cmd_illegal ? S_DONE : S_CALC;
      S_CALC: state_nxt = S_REQ;
      S_REQ:  if (req_ready) state_nxt = S_WAIT;
      S_WAIT: begin
        if (req_done) begin
          if (req_err && ABORT_ON_ERR) state_nxt = S_DONE;
          else if (remaining == '0)    state_nxt = S_DONE;
          else                         state_nxt = S_CALC;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      remaining  <= '0;
      err_sticky <= 1'b0;
      req_addr   <= '0;
      req_len    <= '0;
      burst_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr       <= cmd_addr;
            remaining  <= cmd_bytes >> ADDR_LSB;
            err_sticky <= cmd_illegal;
            burst_cnt  <= '0;
          end
        end
        S_CALC: begin
          req_addr <= addr;
          req_len  <= calc_len;
        end
        S_REQ: begin
          if (req_ready) begin
            addr      <= addr + (AXI_ADDR_W'(req_len) << ADDR_LSB);
            remaining <= remaining - LEN_W'(req_len);
          end
        end
        S_WAIT: begin
          if (req_done) begin
            burst_cnt <= burst_cnt + 16'd1;
            if (req_err) err_sticky <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == S_IDLE) && rst_n;
  assign req_valid = (state == S_REQ);
  assign busy      = (state != S_IDLE);
  assign cmd_done  = (state == S_DONE);
  assign cmd_err   = (state == S_DONE) && err_sticky;

`ifndef SYNTHESIS
  // A completion the splitter is not waiting for is dropped; flag it.
  assert property (@(posedge clk) disable iff (!rst_n) req_done |-> state == S_WAIT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ldb_burst_splitter.sv
`default_nettype none
// ============================================================================
// tb_ldb_burst_splitter : directed self-checking bench for ldb_burst_splitter
// Revision: 1.0
// ============================================================================
module tb_ldb_burst_splitter;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_valid_b;
  logic [63:0] cmd_addr;
  logic [31:0] cmd_bytes;
  logic        req_ready, req_done, req_done_b, req_err;

  logic        cmd_ready, cmd_done, cmd_err, req_valid, busy;
  logic [63:0] req_addr;
  logic [8:0]  req_len;
  logic [15:0] burst_cnt;

  logic        cmd_ready_b, cmd_done_b, cmd_err_b, req_valid_b, busy_b;
  logic [63:0] req_addr_b;
  logic [8:0]  req_len_b;
  logic [15:0] burst_cnt_b;

  int vectors = 0;
  int miscompares = 0;

  ldb_burst_splitter #(.ABORT_ON_ERR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes),
    .cmd_done(cmd_done), .cmd_err(cmd_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .req_done(req_done), .req_err(req_err), .busy(busy), .burst_cnt(burst_cnt)
  );

  ldb_burst_splitter #(.ABORT_ON_ERR(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes),
    .cmd_done(cmd_done_b), .cmd_err(cmd_err_b),
    .req_valid(req_valid_b), .req_ready(req_ready), .req_addr(req_addr_b), .req_len(req_len_b),
    .req_done(req_done_b), .req_err(req_err), .busy(busy_b), .burst_cnt(burst_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a command on the selected instance; returns one cycle after accept.
  task automatic send_cmd(input bit b, input logic [63:0] a, input logic [31:0] n);
    cmd_addr  = a;
    cmd_bytes = n;
    chk("cmd_ready", b ? cmd_ready_b : cmd_ready, 1);
    if (b) cmd_valid_b = 1'b1; else cmd_valid = 1'b1;
    tick();
    cmd_valid   = 1'b0;
    cmd_valid_b = 1'b0;
    chk("busy_after_accept", b ? busy_b : busy, 1);
  endtask

  // In S_CALC: no request yet, next cycle the request appears.
  task automatic calc_gap(input bit b);
    chk("req_valid_calc", b ? req_valid_b : req_valid, 0);
    chk("cmd_done_calc", b ? cmd_done_b : cmd_done, 0);
    tick();
  endtask

  task automatic serve_burst(input bit b, input logic [63:0] a, input logic [8:0] l,
                             input int hold, input bit err);
    chk("req_valid", b ? req_valid_b : req_valid, 1);
    chk("req_addr", b ? req_addr_b : req_addr, a);
    chk("req_len", b ? req_len_b : req_len, l);
    for (int i = 0; i < hold; i++) begin
      req_ready = 1'b0;
      tick();
      chk("hold_valid", b ? req_valid_b : req_valid, 1);
      chk("hold_addr", b ? req_addr_b : req_addr, a);
      chk("hold_len", b ? req_len_b : req_len, l);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("req_valid_wait", b ? req_valid_b : req_valid, 0);
    tick();
    if (b) req_done_b = 1'b1; else req_done = 1'b1;
    req_err = err;
    tick();
    req_done   = 1'b0;
    req_done_b = 1'b0;
    req_err    = 1'b0;
  endtask

  task automatic finish_cmd(input bit b, input bit err, input logic [15:0] cnt);
    chk("cmd_done", b ? cmd_done_b : cmd_done, 1);
    chk("cmd_err", b ? cmd_err_b : cmd_err, err);
    chk("burst_cnt", b ? burst_cnt_b : burst_cnt, cnt);
    chk("req_valid_done", b ? req_valid_b : req_valid, 0);
    tick();
    chk("cmd_done_pulse", b ? cmd_done_b : cmd_done, 0);
    chk("busy_idle", b ? busy_b : busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_valid_b = 1'b0;
    cmd_addr = '0; cmd_bytes = '0;
    req_ready = 1'b0; req_done = 1'b0; req_done_b = 1'b0; req_err = 1'b0;
    repeat (3) tick();

    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_len", req_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_burst_cnt", burst_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Single burst
    send_cmd(0, 64'h1000, 32'd64);
    calc_gap(0);
    serve_burst(0, 64'h1000, 9'd4, 0, 0);
    finish_cmd(0, 0, 16'd1);

    // 4KB boundary crossing
    send_cmd(0, 64'h0FC0, 32'd128);
    calc_gap(0);
    serve_burst(0, 64'h0FC0, 9'd4, 0, 0);
    calc_gap(0);
    serve_burst(0, 64'h1000, 9'd4, 0, 0);
    finish_cmd(0, 0, 16'd2);

    // MAX_BURST split with back-pressure on the second request
    send_cmd(0, 64'h0, 32'd1024);
    calc_gap(0);
    serve_burst(0, 64'h000, 9'd16, 0, 0);
    calc_gap(0);
    serve_burst(0, 64'h100, 9'd16, 5, 0);
    calc_gap(0);
    serve_burst(0, 64'h200, 9'd16, 0, 0);
    calc_gap(0);
    serve_burst(0, 64'h300, 9'd16, 0, 0);
    finish_cmd(0, 0, 16'd4);

    // Error abort
    send_cmd(0, 64'h0, 32'd1024);
    calc_gap(0);
    serve_burst(0, 64'h000, 9'd16, 0, 0);
    calc_gap(0);
    serve_burst(0, 64'h100, 9'd16, 0, 1);
    finish_cmd(0, 1, 16'd2);
    tick();
    chk("no_req_after_abort", req_valid, 0);

    // Sticky error without abort
    send_cmd(1, 64'h0, 32'd1024);
    calc_gap(1);
    serve_burst(1, 64'h000, 9'd16, 0, 0);
    calc_gap(1);
    serve_burst(1, 64'h100, 9'd16, 0, 1);
    calc_gap(1);
    serve_burst(1, 64'h200, 9'd16, 0, 0);
    calc_gap(1);
    serve_burst(1, 64'h300, 9'd16, 0, 0);
    finish_cmd(1, 1, 16'd4);

    // Illegal commands complete with error one cycle after accept
    send_cmd(0, 64'h1008, 32'd64);
    finish_cmd(0, 1, 16'd0);
    send_cmd(0, 64'h1000, 32'd0);
    finish_cmd(0, 1, 16'd0);
    send_cmd(0, 64'h1000, 32'd24);
    finish_cmd(0, 1, 16'd0);

    // Reset while waiting on the second completion
    send_cmd(0, 64'h0, 32'd1024);
    calc_gap(0);
    serve_burst(0, 64'h000, 9'd16, 0, 0);
    calc_gap(0);
    chk("mid_req_valid", req_valid, 1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("mid_wait_busy", busy, 1);
    chk("mid_burst_cnt", burst_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_req_valid", req_valid, 0);
    chk("async_burst_cnt", burst_cnt, 0);
    chk("async_req_len", req_len, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_done", cmd_done, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", cmd_done, 0);
    send_cmd(0, 64'h2000, 32'd64);
    chk("restart_cnt", burst_cnt, 0);
    calc_gap(0);
    serve_burst(0, 64'h2000, 9'd4, 0, 0);
    finish_cmd(0, 0, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
